// File: rtl/id_hazard_stage_pkg.sv
// Shared decode-stage definitions: instruction/register types, control encodings,
// opcode constants and the source-operand usage helpers.
package id_hazard_stage_pkg;

  typedef logic [31:0] instruction;
  typedef logic [31:0] instructionAddrPath;
  typedef logic [4:0]  regAddr;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } ctrALU;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JUMP
  } ctrBranch;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R || op == OP_S || op == OP_B);
  endfunction

  function automatic ctrALU alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_hazard_stage_decoder.sv
// Combinational RV32I instruction decoder: control signals, register fields and
// the sign-extended immediate.
module id_hazard_stage_decoder
  import id_hazard_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  instruction        insn_i,
  output logic              reg_write_o,
  output logic              data_write_o,
  output logic              reg_select_o,
  output logic              mem_read_o,
  output ctrBranch          branch_o,
  output ctrALU             alu_o,
  output regAddr            rs1_o,
  output regAddr            rs2_o,
  output regAddr            rd_o,
  output logic [XLEN-1:0]   offset_o
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] imm;

  assign op    = insn_i[6:0];
  assign f3    = insn_i[14:12];
  assign rs1_o = insn_i[19:15];
  assign rs2_o = insn_i[24:20];
  assign rd_o  = insn_i[11:7];
  assign offset_o = XLEN'($signed(imm));

  // NOTE: every output gets a default first, so no path through the case leaves a latch.
  always_comb begin
    reg_write_o  = 1'b0;
    data_write_o = 1'b0;
    reg_select_o = 1'b0;
    mem_read_o   = 1'b0;
    branch_o     = BR_NONE;
    alu_o        = ALU_ADD;
    imm          = '0;
    case (op)
      OP_R: begin
        reg_write_o = 1'b1;
        alu_o       = alu_sel(f3, insn_i[30]);
      end
      OP_IMM: begin
        reg_write_o = 1'b1;
        alu_o       = alu_sel(f3, insn_i[30] & (f3 == 3'b101));
        imm         = {{20{insn_i[31]}}, insn_i[31:20]};
      end
      OP_LOAD: begin
        reg_write_o  = 1'b1;
        reg_select_o = 1'b1;
        mem_read_o   = 1'b1;
        imm          = {{20{insn_i[31]}}, insn_i[31:20]};
      end
      OP_S: begin
        data_write_o = 1'b1;
        imm          = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      end
      OP_B: begin
        alu_o = ALU_SUB;
        imm   = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
        case (f3)
          3'b000:  branch_o = BR_EQ;
          3'b001:  branch_o = BR_NE;
          3'b100:  branch_o = BR_LT;
          3'b101:  branch_o = BR_GE;
          3'b110:  branch_o = BR_LTU;
          3'b111:  branch_o = BR_GEU;
          default: branch_o = BR_NONE;
        endcase
      end
      OP_LUI: begin
        reg_write_o = 1'b1;
        alu_o       = ALU_PASSB;
        imm         = {insn_i[31:12], 12'b0};
      end
      OP_AUIPC: begin
        reg_write_o = 1'b1;
        imm         = {insn_i[31:12], 12'b0};
      end
      OP_JAL: begin
        reg_write_o = 1'b1;
        branch_o    = BR_JUMP;
        imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
      end
      OP_JALR: begin
        reg_write_o = 1'b1;
        branch_o    = BR_JUMP;
        imm         = {{20{insn_i[31]}}, insn_i[31:20]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_hazard_stage_hazard_unit.sv
// Combinational RAW hazard detector: load-use only with forwarding, any pending
// write in EX or MEM without it. Register x0 never creates a dependency.
module id_hazard_stage_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter bit FORWARDING = 1'b1
) (
  input  logic                  if_valid_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  uses_rs1_i,
  input  logic                  uses_rs2_i,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_reg_write_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_reg_write_i,
  output logic                  hazard_o
);

  function automatic logic hit(input logic [REG_ADDR_W-1:0] src, input logic en);
    return en && (src != '0) &&
           ((uses_rs1_i && rs1_i == src) || (uses_rs2_i && rs2_i == src));
  endfunction

  logic fwd_hit, raw_hit;

  assign fwd_hit  = hit(ex_rd_i, ex_valid_i & ex_mem_read_i);
  assign raw_hit  = hit(ex_rd_i, ex_valid_i & ex_reg_write_i) | hit(mem_rd_i, mem_reg_write_i);
  assign hazard_o = if_valid_i & (FORWARDING ? fwd_hit : raw_hit);

endmodule

// File: rtl/id_hazard_stage.sv
// Decode stage with ID/EX register and stall/bubble/flush control; flush beats
// backpressure, which beats hazard stalls. Counters saturate at all-ones.
module id_hazard_stage
  import id_hazard_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit FORWARDING = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [31:0]           insn,
  input  logic [XLEN-1:0]       pc,
  input  logic                  ex_ready,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  output logic                  id_ready,
  output logic                  ex_valid,
  output logic                  registerWriteEnable,
  output logic                  dataWriteEnable,
  output logic                  regSelect,
  output logic                  mem_read,
  output ctrBranch              branchCtr,
  output ctrALU                 aluCtr,
  output logic [REG_ADDR_W-1:0] regA,
  output logic [REG_ADDR_W-1:0] regB,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       offset,
  output logic [XLEN-1:0]       pc_out,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef struct packed {
    logic                  valid;
    logic                  rwe;
    logic                  dwe;
    logic                  rsel;
    logic                  mrd;
    ctrBranch              br;
    ctrALU                 alu;
    logic [REG_ADDR_W-1:0] ra;
    logic [REG_ADDR_W-1:0] rb;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       offset;
    logic [XLEN-1:0]       pc;
  } idex_t;

  idex_t            idex_q, idex_d, dec;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  regAddr           dec_rs1, dec_rs2, dec_rd;
  logic             hazard;

  id_hazard_stage_decoder #(.XLEN(XLEN)) u_decoder (
    .insn_i       (insn),
    .reg_write_o  (dec.rwe),
    .data_write_o (dec.dwe),
    .reg_select_o (dec.rsel),
    .mem_read_o   (dec.mrd),
    .branch_o     (dec.br),
    .alu_o        (dec.alu),
    .rs1_o        (dec_rs1),
    .rs2_o        (dec_rs2),
    .rd_o         (dec_rd),
    .offset_o     (dec.offset)
  );

  assign dec.valid = if_valid;
  assign dec.ra    = REG_ADDR_W'(dec_rs1);
  assign dec.rb    = REG_ADDR_W'(dec_rs2);
  assign dec.rd    = REG_ADDR_W'(dec_rd);
  assign dec.pc    = pc;

  id_hazard_stage_hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W),
    .FORWARDING (FORWARDING)
  ) u_hazard (
    .if_valid_i      (if_valid),
    .rs1_i           (dec.ra),
    .rs2_i           (dec.rb),
    .uses_rs1_i      (uses_rs1(insn[6:0])),
    .uses_rs2_i      (uses_rs2(insn[6:0])),
    .ex_valid_i      (idex_q.valid),
    .ex_rd_i         (idex_q.rd),
    .ex_reg_write_i  (idex_q.rwe),
    .ex_mem_read_i   (idex_q.mrd),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .hazard_o        (hazard)
  );

  always_comb begin
    idex_d  = idex_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (flush) begin
      idex_d.valid = 1'b0;
      idex_d.rwe   = 1'b0;
      idex_d.dwe   = 1'b0;
      idex_d.mrd   = 1'b0;
      flush_d      = (&flush_q) ? flush_q : flush_q + CNT_W'(1);
    end else if (!ex_ready) begin
      idex_d = idex_q;
    end else if (hazard) begin
      idex_d.valid = 1'b0;
      idex_d.rwe   = 1'b0;
      idex_d.dwe   = 1'b0;
      idex_d.mrd   = 1'b0;
      stall_d      = (&stall_q) ? stall_q : stall_q + CNT_W'(1);
    end else begin
      idex_d = dec;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      idex_q  <= idex_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign id_ready            = rst & (flush | (ex_ready & ~hazard));
  assign ex_valid            = idex_q.valid;
  assign registerWriteEnable = idex_q.rwe;
  assign dataWriteEnable     = idex_q.dwe;
  assign regSelect           = idex_q.rsel;
  assign mem_read            = idex_q.mrd;
  assign branchCtr           = idex_q.br;
  assign aluCtr              = idex_q.alu;
  assign regA                = idex_q.ra;
  assign regB                = idex_q.rb;
  assign rd                  = idex_q.rd;
  assign offset              = idex_q.offset;
  assign pc_out              = idex_q.pc;
  assign stall_count         = stall_q;
  assign flush_count         = flush_q;

endmodule
